// File: rtl/mux_select_arbiter_if.sv
// Handshake bundle between the round-robin arbiter, the 4:1 mux select bus and
// the downstream consumer. The arbiter uses the master view.
interface mux_select_arbiter_if;
    logic [3:0] req;
    logic       ready;
    logic [1:0] select;
    logic [3:0] grant;
    logic       valid;
    logic [3:0] ack;

    modport master (
        input  req,
        input  ready,
        output select,
        output grant,
        output valid,
        output ack
    );

    modport slave (
        output req,
        output ready,
        input  select,
        input  grant,
        input  valid,
        input  ack
    );
endinterface

// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter driving the 4:1 mux select bus with a per-owner transfer quantum.
// Optional macro MUX_ARB_PRIO0_EN: channel 0 wins every arbitration and ignores the quantum.
module mux_select_arbiter #(
    parameter int QUANTUM = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mux_select_arbiter_if.master  bus
);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] select_q, select_d;
    logic [3:0] grant_q, grant_d;
    logic       valid_q, valid_d;
    logic [1:0] last_q, last_d;
    logic [3:0] beats_q, beats_d;

    logic [3:0] sel_onehot;
    logic [3:0] others;
    logic       own_req;
    logic       xfer;
    logic       may_extend;
    logic [1:0] base;
    logic [2:0] win;
    logic       do_load;

    // Returns {found, index}: first set bit of r searching upward from after+1.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] after);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = after + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
`ifdef MUX_ARB_PRIO0_EN
        if (r[0]) begin
            res = 3'b100;
        end
`endif
        return res;
    endfunction

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sel_dec
            assign sel_onehot[gi] = (select_q == 2'(gi));
        end
    endgenerate

    assign xfer    = valid_q & bus.ready;
    assign others  = bus.req & ~sel_onehot;
    assign own_req = bus.req[select_q];
    assign base    = (state_q == ST_GRANT) ? select_q : last_q;
    assign win     = pick(bus.req, base);

`ifdef MUX_ARB_PRIO0_EN
    assign may_extend = (({1'b0, beats_q} + 5'd1) < 5'(QUANTUM)) || (select_q == 2'd0);
`else
    assign may_extend = (({1'b0, beats_q} + 5'd1) < 5'(QUANTUM));
`endif

    always_comb begin
        state_d  = state_q;
        select_d = select_q;
        grant_d  = grant_q;
        valid_d  = valid_q;
        last_d   = last_q;
        beats_d  = beats_q;
        do_load  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    do_load = 1'b1;
                end else begin
                    valid_d = 1'b0;
                    grant_d = 4'b0000;
                end
            end
            ST_GRANT: begin
                if (xfer && own_req && ((others == 4'b0000) || may_extend)) begin
                    // A lone requester keeps its count at zero so it never gets preempted later by stale beats.
                    beats_d = (others == 4'b0000) ? 4'd0 : beats_q + 4'd1;
                end else if (xfer || !own_req) begin
                    if (|bus.req) begin
                        do_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        grant_d = 4'b0000;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                grant_d = 4'b0000;
            end
        endcase

        if (do_load && win[2]) begin
            state_d  = ST_GRANT;
            select_d = win[1:0];
            grant_d  = 4'(4'b0001 << win[1:0]);
            valid_d  = 1'b1;
            last_d   = win[1:0];
            beats_d  = 4'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            select_q <= 2'd0;
            grant_q  <= 4'b0000;
            valid_q  <= 1'b0;
            last_q   <= 2'd3;
            beats_q  <= 4'd0;
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
            grant_q  <= grant_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            beats_q  <= beats_d;
        end
    end

    assign bus.select = select_q;
    assign bus.grant  = grant_q;
    assign bus.valid  = valid_q;
    assign bus.ack    = xfer ? grant_q : 4'b0000;

endmodule
